uart_probe_bridge: RTL and testbench
====================================

UART_PROBE_BRIDGE -- requirements
Module: uart_probe_bridge

Interface
REQ-001 SHALL have parameter CLK_DIV, default 16: clock cycles per bit; legal range 4..4095; even values only.
REQ-002 SHALL have parameter DATA_BITS, default 8: data bits per frame; legal range 5..8.
REQ-003 SHALL have parameter STOP_BITS, default 1: stop bits per frame; legal values 1 or 2.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4: RX FIFO entries; power of 2, legal range 2..64.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port tx_data, input, DATA_BITS: byte to transmit.
REQ-008 SHALL have ports tx_valid (input, 1) and tx_ready (output, 1): TX handshake.
REQ-009 SHALL have port cts, input, 1 bit: clear-to-send; gates the start of a frame.
REQ-010 SHALL have port uart_tx, output, 1 bit: serial out; idle level 1.
REQ-011 SHALL have port uart_rx, input, 1 bit: serial in; asynchronous to clk.
REQ-012 SHALL have ports rx_data (output, DATA_BITS), rx_valid (output, 1) and rx_ready (input, 1): RX FIFO head and handshake.
REQ-013 SHALL have port rx_level, output, $clog2(FIFO_DEPTH)+1 bits: RX FIFO occupancy.
REQ-014 SHALL have port rts, output, 1 bit: 1 when the RX FIFO is not full.
REQ-015 SHALL have port frame_err, output, 1 bit: one-cycle pulse per bad stop bit.
REQ-016 SHALL have port overrun, output, 1 bit: sticky flag for a frame dropped on a full FIFO.
REQ-017 SHALL have port err_clr, input, 1 bit: synchronous clear of overrun.

Function
REQ-018 TX FSM SHALL have states IDLE, WAIT_CTS, START, DATA, STOP; tx_ready=1 only in IDLE.
REQ-019 On tx_valid&tx_ready, SHALL latch tx_data; next state is START if cts=1 that cycle, else WAIT_CTS.
REQ-020 WAIT_CTS SHALL hold uart_tx=1 and move to START the cycle after cts is sampled 1.
REQ-021 uart_tx SHALL be registered: 0 for CLK_DIV cycles from the cycle after START is entered.
REQ-022 After the start bit, uart_tx SHALL send the data bits LSB first, CLK_DIV cycles each.
REQ-023 After the data bits, uart_tx SHALL send STOP_BITS*CLK_DIV cycles of 1, then the FSM SHALL return to IDLE.
REQ-024 cts SHALL NOT be checked once START is entered; a frame in progress always completes.
REQ-025 uart_rx SHALL pass through a 2-FF synchronizer; RX FSM states IDLE, START, DATA, STOP.
REQ-026 In RX IDLE, a synchronized 1->0 edge SHALL start a CLK_DIV/2 counter; the line is sampled at the end of that count.
REQ-027 If the start-bit sample is 1, SHALL return to IDLE (glitch rejected); no flags set.
REQ-028 Data bits and the first stop bit SHALL be sampled every CLK_DIV cycles after the start-bit sample.
REQ-029 Stop sample 1 with FIFO not full SHALL push the assembled word into the FIFO.
REQ-030 Stop sample 1 with FIFO full and no pop that cycle SHALL drop the word and set overrun.
REQ-031 Stop sample 0 SHALL pulse frame_err for one cycle and discard the word.
REQ-032 RX SHALL return to IDLE the cycle after the stop sample; a second stop bit is not checked.
REQ-033 FIFO SHALL be first-word fall-through: rx_valid = (rx_level!=0); rx_data = oldest entry.
REQ-034 Pop SHALL occur on rx_valid&rx_ready; push and pop in the same cycle SHALL both happen (full included, no overrun).
REQ-035 Pointers SHALL wrap modulo FIFO_DEPTH; rx_level SHALL update the cycle after the push/pop edge.
REQ-036 err_clr=1 SHALL clear overrun next cycle; if a new overrun occurs in the same cycle, set SHALL win.

Reset
REQ-037 While rst=1, SHALL force uart_tx=1, tx_ready=0, rx_valid=0, rx_level=0, rts=1, frame_err=0, overrun=0, both FSMs IDLE, FIFO emptied.
REQ-038 Reset mid-frame SHALL abort immediately (uart_tx=1); tx_ready SHALL be 1 the first cycle after rst falls.

Verification (CLK_DIV=16, DATA_BITS=8, STOP_BITS=1, FIFO_DEPTH=4)
REQ-039 tx 0xA5, cts=1 -> uart_tx: 16 cycles 0, then 1,0,1,0,0,1,0,1 (16 cycles each), 16 cycles 1; tx_ready low for 160 cycles.
REQ-040 uart_tx looped to uart_rx, send 0x3C -> rx_valid=1, rx_data=0x3C, rx_level=1; pop -> rx_level=0.
REQ-041 cts=0, accept 0x55 -> uart_tx held 1 for 100 cycles; raise cts -> start bit begins within 2 cycles.
REQ-042 rx_ready=0, 5 frames 0x01..0x05 -> rx_level=4, rts=0, overrun=1; pops yield 0x01..0x04; err_clr -> overrun=0.
REQ-043 frame 0x77 with stop bit driven 0 -> one frame_err pulse, rx_level unchanged; uart_rx low 4 cycles -> no frame, no flags.
REQ-044 rst asserted at bit 3 of a TX frame -> uart_tx=1 immediately; after release, a new 0x12 frame transmits correctly.

Source files
------------

// File: rtl/uart_probe_bridge.sv
// uart_probe_bridge: UART transmitter gated by CTS plus a receiver feeding a first-word-fall-through FIFO
//   clk, rst                      : clock, asynchronous active-high reset
//   tx_data, tx_valid, tx_ready   : TX word and handshake (ready only while TX is idle)
//   cts                           : clear-to-send, checked only before a frame starts
//   uart_tx, uart_rx              : serial out (idle 1) and asynchronous serial in
//   rx_data, rx_valid, rx_ready   : RX FIFO head and pop handshake
//   rx_level, rts                 : FIFO occupancy and "not full" flow-control output
//   frame_err, overrun, err_clr   : bad-stop pulse, sticky dropped-frame flag and its clear
module uart_probe_bridge #(
   parameter int CLK_DIV    = 16,
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [DATA_BITS-1:0]          tx_data,
   input  logic                          tx_valid,
   output logic                          tx_ready,
   input  logic                          cts,
   output logic                          uart_tx,
   input  logic                          uart_rx,
   output logic [DATA_BITS-1:0]          rx_data,
   output logic                          rx_valid,
   input  logic                          rx_ready,
   output logic [$clog2(FIFO_DEPTH):0]   rx_level,
   output logic                          rts,
   output logic                          frame_err,
   output logic                          overrun,
   input  logic                          err_clr
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam logic [12:0]   TX_BIT_END  = 13'(CLK_DIV - 1);
   localparam logic [12:0]   TX_STOP_END = 13'(STOP_BITS * CLK_DIV - 1);
   localparam logic [11:0]   RX_HALF_END = 12'(CLK_DIV / 2 - 1);
   localparam logic [11:0]   RX_BIT_END  = 12'(CLK_DIV - 1);
   localparam logic [2:0]    DB_END      = 3'(DATA_BITS - 1);
   localparam logic [LW-1:0] FULL_LVL    = LW'(FIFO_DEPTH);
   typedef enum logic [2:0] {TX_IDLE, TX_WAIT_CTS, TX_START, TX_DATA, TX_STOP} tx_state_t;
   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
   tx_state_t r_tx_state, w_tx_next;
   logic [12:0] r_tx_cnt;
   logic [2:0] r_tx_bit;
   logic [DATA_BITS-1:0] r_tx_sh;
   logic r_tx, w_tx_end, w_tx_acc, w_tx_bit;
   rx_state_t r_rx_state, w_rx_next;
   logic r_rx_s1, r_rx_s2, r_rx_prev;
   logic [11:0] r_rx_cnt;
   logic [2:0] r_rx_bit;
   logic [DATA_BITS-1:0] r_rx_sh;
   logic r_ferr, r_ovr;
   logic w_rx_half, w_rx_bend, w_stop_smp, w_push_req, w_push, w_pop, w_full;
   logic [DATA_BITS-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wp, r_rp;
   logic [LW-1:0] r_level;
   // tx_ready is masked by rst so it reads 0 while reset is held, yet 1 the first cycle after release
   assign tx_ready = (r_tx_state == TX_IDLE) && !rst;
   assign w_tx_acc = tx_valid && tx_ready;
   assign w_tx_end = r_tx_cnt == ((r_tx_state == TX_STOP) ? TX_STOP_END : TX_BIT_END);
   assign w_tx_bit = (r_tx_state == TX_START) ? 1'b0 : (r_tx_state == TX_DATA) ? r_tx_sh[0] : 1'b1;
   assign uart_tx  = r_tx;
   always_comb begin
      w_tx_next = r_tx_state;
      case (r_tx_state)
         TX_IDLE:     if (w_tx_acc) w_tx_next = cts ? TX_START : TX_WAIT_CTS;
         TX_WAIT_CTS: if (cts) w_tx_next = TX_START;
         TX_START:    if (w_tx_end) w_tx_next = TX_DATA;
         TX_DATA:     if (w_tx_end && r_tx_bit == DB_END) w_tx_next = TX_STOP;
         TX_STOP:     if (w_tx_end) w_tx_next = TX_IDLE;
         default:     w_tx_next = TX_IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_tx_state <= TX_IDLE;
      else r_tx_state <= w_tx_next;
   end
   // uart_tx is the registered line level, so it trails the state by one cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tx     <= 1'b1;
         r_tx_cnt <= '0;
         r_tx_bit <= '0;
         r_tx_sh  <= '0;
      end else begin
         r_tx     <= w_tx_bit;
         r_tx_cnt <= (w_tx_end || r_tx_state == TX_IDLE || r_tx_state == TX_WAIT_CTS) ? '0 : r_tx_cnt + 13'd1;
         r_tx_bit <= (r_tx_state != TX_DATA) ? 3'd0 : w_tx_end ? r_tx_bit + 3'd1 : r_tx_bit;
         r_tx_sh  <= w_tx_acc ? tx_data : (r_tx_state == TX_DATA && w_tx_end) ? r_tx_sh >> 1 : r_tx_sh;
      end
   end
   assign w_rx_half  = r_rx_cnt == RX_HALF_END;
   assign w_rx_bend  = r_rx_cnt == RX_BIT_END;
   assign w_stop_smp = (r_rx_state == RX_STOP) && w_rx_bend;
   assign w_push_req = w_stop_smp && r_rx_s2;
   always_comb begin
      w_rx_next = r_rx_state;
      case (r_rx_state)
         RX_IDLE:  if (r_rx_prev && !r_rx_s2) w_rx_next = RX_START;
         RX_START: if (w_rx_half) w_rx_next = r_rx_s2 ? RX_IDLE : RX_DATA;
         RX_DATA:  if (w_rx_bend && r_rx_bit == DB_END) w_rx_next = RX_STOP;
         RX_STOP:  if (w_rx_bend) w_rx_next = RX_IDLE;
         default:  w_rx_next = RX_IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_rx_state <= RX_IDLE;
      else r_rx_state <= w_rx_next;
   end
   // counter restarts on every state change, so samples land mid-bit after the half-bit start delay
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rx_s1   <= 1'b1;
         r_rx_s2   <= 1'b1;
         r_rx_prev <= 1'b1;
         r_rx_cnt  <= '0;
         r_rx_bit  <= '0;
         r_rx_sh   <= '0;
         r_ferr    <= 1'b0;
         r_ovr     <= 1'b0;
      end else begin
         r_rx_s1   <= uart_rx;
         r_rx_s2   <= r_rx_s1;
         r_rx_prev <= r_rx_s2;
         r_rx_cnt  <= (w_rx_next != r_rx_state || r_rx_state == RX_IDLE || w_rx_bend) ? '0 : r_rx_cnt + 12'd1;
         r_rx_bit  <= (r_rx_state != RX_DATA) ? 3'd0 : w_rx_bend ? r_rx_bit + 3'd1 : r_rx_bit;
         r_rx_sh   <= (r_rx_state == RX_DATA && w_rx_bend) ? {r_rx_s2, r_rx_sh[DATA_BITS-1:1]} : r_rx_sh;
         r_ferr    <= w_stop_smp && !r_rx_s2;
         r_ovr     <= (w_push_req && w_full && !w_pop) ? 1'b1 : err_clr ? 1'b0 : r_ovr;
      end
   end
   // a pop in the same cycle frees the slot, so a push into a full FIFO still succeeds
   assign w_full    = r_level == FULL_LVL;
   assign w_pop     = rx_valid && rx_ready;
   assign w_push    = w_push_req && (!w_full || w_pop);
   assign rx_valid  = r_level != '0;
   assign rx_data   = r_mem[r_rp];
   assign rx_level  = r_level;
   assign rts       = !w_full;
   assign frame_err = r_ferr;
   assign overrun   = r_ovr;
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wp] <= r_rx_sh;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_level <= '0;
      end else begin
         r_wp    <= w_push ? r_wp + AW'(1) : r_wp;
         r_rp    <= w_pop ? r_rp + AW'(1) : r_rp;
         r_level <= (w_push && !w_pop) ? r_level + LW'(1) : (w_pop && !w_push) ? r_level - LW'(1) : r_level;
      end
   end
endmodule

// File: tb/tb_uart_probe_bridge.sv
// tb_uart_probe_bridge: randomized scenario bench for uart_probe_bridge against a frame-level model
module tb_uart_probe_bridge;
   localparam int CD = 16;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [7:0] tx_data = '0;
   logic tx_valid = 1'b0, cts = 1'b1, rx_ready = 1'b0, err_clr = 1'b0;
   logic rx_drv = 1'b1, loop = 1'b0, mon_en = 1'b0;
   logic tx_ready, uart_tx, rx_valid, rts, frame_err, overrun, rx_line;
   logic [7:0] rx_data;
   logic [2:0] rx_level;
   int total = 0, bad = 0, ferr_cnt = 0;
   logic [7:0] got_q[$];
   assign rx_line = loop ? uart_tx : rx_drv;
   uart_probe_bridge #(.CLK_DIV(CD), .DATA_BITS(8), .STOP_BITS(1), .FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .cts(cts), .uart_tx(uart_tx), .uart_rx(rx_line), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready), .rx_level(rx_level), .rts(rts), .frame_err(frame_err),
      .overrun(overrun), .err_clr(err_clr)
   );
   always #5 clk = ~clk;
   always @(negedge clk) if (frame_err === 1'b1) ferr_cnt++;
   always @(negedge clk) if (mon_en && rx_valid === 1'b1 && rx_ready) got_q.push_back(rx_data);
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic wait_ready;
      int t = 0;
      while (tx_ready !== 1'b1 && t < 1000) begin
         tick;
         t++;
      end
      total++;
      if (tx_ready !== 1'b1) begin
         bad++;
         $display("FAIL tx_ready_timeout got=%b exp=1", tx_ready);
      end
   endtask
   task automatic send_tx(input logic [7:0] d);
      wait_ready;
      cts = 1'b1;
      tx_data = d;
      tx_valid = 1'b1;
      tick;
      tx_valid = 1'b0;
   endtask
   task automatic send_serial(input logic [7:0] d, input logic stop_v);
      rx_drv = 1'b0;
      repeat (CD) tick;
      for (int i = 0; i < 8; i++) begin
         rx_drv = d[i];
         repeat (CD) tick;
      end
      rx_drv = stop_v;
      repeat (CD) tick;
      rx_drv = 1'b1;
      repeat (CD) tick;
   endtask
   task automatic tx_frame_check(input logic [7:0] d, input string nm);
      logic [9:0] bits;
      logic e;
      int errs = 0, low = 0, first = -1;
      bits = {1'b1, d, 1'b0};
      wait_ready;
      cts = 1'b1;
      tx_data = d;
      tx_valid = 1'b1;
      tick;
      tx_valid = 1'b0;
      for (int k = 0; k <= 10 * CD; k++) begin
         e = (k == 0) ? 1'b1 : bits[(k - 1) / CD];
         if (uart_tx !== e) begin
            errs++;
            if (first < 0) first = k;
         end
         if (tx_ready === 1'b0) low++;
         if (k < 10 * CD) tick;
      end
      total++;
      if (errs != 0) begin
         bad++;
         $display("FAIL %s_wave data=%h wrong_cycles=%0d first_at=%0d exp=0", nm, d, errs, first);
      end
      total++;
      if (low != 10 * CD) begin
         bad++;
         $display("FAIL %s_ready_low got=%0d exp=%0d", nm, low, 10 * CD);
      end
   endtask
   task automatic test_reset;
      rst = 1'b1;
      repeat (3) tick;
      total++;
      if ({uart_tx, tx_ready, rx_valid, rx_level, rts, frame_err, overrun} !== 9'b1_0_0_000_1_0_0) begin
         bad++;
         $display("FAIL reset_outputs got=%b exp=%b", {uart_tx, tx_ready, rx_valid, rx_level, rts, frame_err, overrun}, 9'b100000100);
      end
      rst = 1'b0;
      #1;
      total++;
      if (tx_ready !== 1'b1 || uart_tx !== 1'b1) begin
         bad++;
         $display("FAIL reset_release got=%b%b exp=11", tx_ready, uart_tx);
      end
   endtask
   task automatic test_tx;
      tx_frame_check(8'hA5, "tx_a5");
      repeat (3) tx_frame_check(8'($urandom), "tx_rand");
   endtask
   task automatic test_loopback;
      logic [7:0] d;
      int t;
      loop = 1'b1;
      for (int i = 0; i < 4; i++) begin
         d = (i == 0) ? 8'h3C : 8'($urandom);
         send_tx(d);
         t = 0;
         while (rx_valid !== 1'b1 && t < 400) begin
            tick;
            t++;
         end
         total++;
         if (rx_valid !== 1'b1 || rx_data !== d || rx_level !== 3'd1) begin
            bad++;
            $display("FAIL loop_rx got=%b/%h/%0d exp=1/%h/1", rx_valid, rx_data, rx_level, d);
         end
         rx_ready = 1'b1;
         tick;
         rx_ready = 1'b0;
         total++;
         if (rx_level !== 3'd0 || rx_valid !== 1'b0) begin
            bad++;
            $display("FAIL loop_pop got=%0d/%b exp=0/0", rx_level, rx_valid);
         end
      end
      wait_ready;
      loop = 1'b0;
   endtask
   task automatic test_cts;
      int ones = 0;
      logic found = 1'b0;
      wait_ready;
      cts = 1'b0;
      tx_data = 8'h55;
      tx_valid = 1'b1;
      tick;
      tx_valid = 1'b0;
      total++;
      if (tx_ready !== 1'b0) begin
         bad++;
         $display("FAIL cts_ready got=%b exp=0", tx_ready);
      end
      repeat (100) begin
         if (uart_tx === 1'b1) ones++;
         tick;
      end
      total++;
      if (ones != 100) begin
         bad++;
         $display("FAIL cts_hold got=%0d exp=100", ones);
      end
      cts = 1'b1;
      repeat (2) begin
         tick;
         if (uart_tx === 1'b0) found = 1'b1;
      end
      total++;
      if (!found) begin
         bad++;
         $display("FAIL cts_start got=%b exp=0", uart_tx);
      end
      wait_ready;
   endtask
   task automatic fill_and_drain(input int n, input logic fixed);
      logic [7:0] q[$];
      logic [7:0] d;
      logic ovr_exp = 1'b0;
      rx_ready = 1'b0;
      for (int i = 0; i < n; i++) begin
         d = fixed ? 8'(i + 1) : 8'($urandom);
         send_serial(d, 1'b1);
         if (q.size() < 4) q.push_back(d);
         else ovr_exp = 1'b1;
      end
      total++;
      if (rx_level !== 3'(q.size()) || rts !== (q.size() < 4) || overrun !== ovr_exp) begin
         bad++;
         $display("FAIL fill_state got=%0d/%b/%b exp=%0d/%b/%b", rx_level, rts, overrun, q.size(), q.size() < 4, ovr_exp);
      end
      while (q.size() > 0) begin
         total++;
         if (rx_valid !== 1'b1 || rx_data !== q[0]) begin
            bad++;
            $display("FAIL drain_data got=%b/%h exp=1/%h", rx_valid, rx_data, q[0]);
         end
         rx_ready = 1'b1;
         tick;
         rx_ready = 1'b0;
         void'(q.pop_front());
      end
      total++;
      if (rx_level !== 3'd0 || rts !== 1'b1 || overrun !== ovr_exp) begin
         bad++;
         $display("FAIL drained got=%0d/%b/%b exp=0/1/%b", rx_level, rts, overrun, ovr_exp);
      end
      err_clr = 1'b1;
      tick;
      err_clr = 1'b0;
      total++;
      if (overrun !== 1'b0) begin
         bad++;
         $display("FAIL err_clr got=%b exp=0", overrun);
      end
   endtask
   task automatic test_overrun;
      fill_and_drain(5, 1'b1);
      fill_and_drain($urandom_range(2, 6), 1'b0);
   endtask
   task automatic test_frame_err;
      int f0;
      logic [7:0] d;
      f0 = ferr_cnt;
      send_serial(8'h77, 1'b0);
      total++;
      if (ferr_cnt != f0 + 1 || rx_level !== 3'd0 || overrun !== 1'b0) begin
         bad++;
         $display("FAIL frame_err got=%0d/%0d/%b exp=1/0/0", ferr_cnt - f0, rx_level, overrun);
      end
      f0 = ferr_cnt;
      rx_drv = 1'b0;
      repeat (4) tick;
      rx_drv = 1'b1;
      repeat (3 * CD) tick;
      total++;
      if (ferr_cnt != f0 || rx_level !== 3'd0 || rx_valid !== 1'b0 || overrun !== 1'b0) begin
         bad++;
         $display("FAIL glitch got=%0d/%0d/%b/%b exp=0/0/0/0", ferr_cnt - f0, rx_level, rx_valid, overrun);
      end
      d = 8'($urandom);
      send_serial(d, 1'b1);
      total++;
      if (rx_level !== 3'd1 || rx_data !== d) begin
         bad++;
         $display("FAIL after_glitch got=%0d/%h exp=1/%h", rx_level, rx_data, d);
      end
      rx_ready = 1'b1;
      tick;
      rx_ready = 1'b0;
   endtask
   task automatic test_back_to_back;
      logic [7:0] exp_q[$];
      int t = 0;
      got_q.delete();
      loop = 1'b1;
      rx_ready = 1'b1;
      mon_en = 1'b1;
      for (int i = 0; i < 6; i++) begin
         exp_q.push_back(8'($urandom));
         send_tx(exp_q[i]);
      end
      while (got_q.size() < exp_q.size() && t < 400) begin
         tick;
         t++;
      end
      total++;
      if (got_q.size() != exp_q.size()) begin
         bad++;
         $display("FAIL b2b_count got=%0d exp=%0d", got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         total++;
         if (got_q[i] !== exp_q[i]) begin
            bad++;
            $display("FAIL b2b_data[%0d] got=%h exp=%h", i, got_q[i], exp_q[i]);
         end
      end
      mon_en = 1'b0;
      rx_ready = 1'b0;
      wait_ready;
      loop = 1'b0;
   endtask
   task automatic test_reset_mid;
      logic [7:0] d;
      d = 8'($urandom) & 8'hF7;
      send_tx(d);
      repeat (1 + 4 * CD + 3) tick;
      total++;
      if (uart_tx !== 1'b0) begin
         bad++;
         $display("FAIL mid_bit3 got=%b exp=0", uart_tx);
      end
      rst = 1'b1;
      #1;
      total++;
      if (uart_tx !== 1'b1 || tx_ready !== 1'b0) begin
         bad++;
         $display("FAIL mid_reset got=%b%b exp=10", uart_tx, tx_ready);
      end
      repeat (2) tick;
      rst = 1'b0;
      #1;
      total++;
      if (tx_ready !== 1'b1) begin
         bad++;
         $display("FAIL mid_release got=%b exp=1", tx_ready);
      end
      tx_frame_check(8'h12, "tx_12_after_rst");
   endtask
   initial begin
      test_reset;
      test_tx;
      test_loopback;
      test_cts;
      test_overrun;
      test_frame_err;
      test_back_to_back;
      test_reset_mid;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
